// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//
// Push/pop pointer controller for one dual-port RAM FIFO of the UART/IrDA
// link. The block owns the write and read pointers and arbitrates push
// against pop. It drives the RAM write and read strobes, and it tracks
// occupancy with an EMPTY / ACTIVE / FULL state machine. It never accepts
// a push while FULL or a pop while EMPTY, even when the opposite request
// is accepted in the same cycle.
//
// Parameters
//   WIDTH        pointer / RAM address width; FIFO depth = 2**WIDTH.
//
// Ports
//   i_clock      system clock; all state changes on the rising edge.
//   i_reset      asynchronous, active-high; clears all state.
//   i_push_req   request to write one word this cycle.
//   i_pop_req    request to read one word this cycle.
//   o_wr_en      RAM write strobe (push accepted), combinational.
//   o_wr_addr    RAM write address (registered write pointer).
//   o_rd_en      RAM read strobe (pop accepted), combinational.
//   o_rd_addr    RAM read address (registered read pointer).
//   o_pop_valid  RAM read data valid, one cycle after o_rd_en.
//   o_count      current occupancy, 0 .. 2**WIDTH.
//   o_empty      FIFO empty (decoded from state).
//   o_full       FIFO full (decoded from state).
//   o_overflow   sticky: push request seen while full.
//   o_underflow  sticky: pop request seen while empty.
//
// Configuration macro
//   FIFO_ERR_FLAGS_EN  when defined, this macro builds the sticky
//                      overflow/underflow flag registers. When it is not
//                      defined, both flag outputs are tied to 0.
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push_req,
  input  logic             i_pop_req,
  output logic             o_wr_en,
  output logic [WIDTH-1:0] o_wr_addr,
  output logic             o_rd_en,
  output logic [WIDTH-1:0] o_rd_addr,
  output logic             o_pop_valid,
  output logic [WIDTH:0]   o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  // Occupancy constants, sized to the count register.
  localparam logic [WIDTH:0] C_ONE    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] C_ALMOST = {1'b0, {WIDTH{1'b1}}};

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_wr_ptr;
  logic [WIDTH-1:0] r_rd_ptr;
  logic [WIDTH:0]   r_count;
  logic             r_pop_valid;
  logic             w_push_acc;
  logic             w_pop_acc;

  // Acceptance depends only on the state. A pop in FULL does not open room
  // for a push in the same cycle, so the RAM never reads and writes one
  // address together. A push in EMPTY does not feed a same-cycle pop, so
  // there is no fall-through path.
  assign w_push_acc = i_push_req & (r_state != ST_FULL);
  assign w_pop_acc  = i_pop_req  & (r_state != ST_EMPTY);

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push_acc) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_push_acc && !w_pop_acc && (r_count == C_ALMOST))
          w_state_next = ST_FULL;
        else if (w_pop_acc && !w_push_acc && (r_count == C_ONE))
          w_state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_pop_acc) w_state_next = ST_ACTIVE;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers sample pre-edge values.
    if (i_reset) r_state <= ST_EMPTY;
    else         r_state <= w_state_next;
  end

  // Pointers, occupancy and read-data-valid pipeline.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      // The pointers wrap naturally at 2**WIDTH.
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_acc && !w_pop_acc)      r_count <= r_count + 1'b1;
      else if (w_pop_acc && !w_push_acc) r_count <= r_count - 1'b1;
      r_pop_valid <= w_pop_acc;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags. They are set by any request made against the
  // matching boundary state, and only reset clears them.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_push_req && (r_state == ST_FULL))  r_overflow  <= 1'b1;
      if (i_pop_req  && (r_state == ST_EMPTY)) r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_wr_en     = w_push_acc;
  assign o_rd_en     = w_pop_acc;
  assign o_wr_addr   = r_wr_ptr;
  assign o_rd_addr   = r_rd_ptr;
  assign o_pop_valid = r_pop_valid;
  assign o_count     = r_count;
  assign o_empty     = (r_state == ST_EMPTY);
  assign o_full      = (r_state == ST_FULL);

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
//
// Self-checking bench for fifo_ptr_ctrl (WIDTH = 4, depth 16).
// The bench keeps a simple occupancy model: an integer count and two
// integer pointers. Each falling edge compares every DUT output against
// that model. Directed phases drive the stimulus. Literal expectations,
// worked out by hand, pin the model at the points of interest.
// -----------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

  localparam int W     = 4;
  localparam int DEPTH = 1 << W;

`ifdef FIFO_ERR_FLAGS_EN
  localparam int FLAGS_ON = 1;
`else
  localparam int FLAGS_ON = 0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         push_req;
  logic         pop_req;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic         rd_en;
  logic [W-1:0] rd_addr;
  logic         pop_valid;
  logic [W:0]   count;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  int n_cmp = 0;
  int n_err = 0;

  fifo_ptr_ctrl #(.WIDTH(W)) dut (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_push_req (push_req),
    .i_pop_req  (pop_req),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_rd_en    (rd_en),
    .o_rd_addr  (rd_addr),
    .o_pop_valid(pop_valid),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (overflow),
    .o_underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- occupancy model ----------------
  // The model treats the FIFO as a count of stored words. A push is taken
  // unless the FIFO already holds DEPTH words. A pop is taken unless it
  // holds none. Each request is judged against the occupancy at the start
  // of the cycle.
  int m_count = 0;
  int m_wr    = 0;
  int m_rd    = 0;
  int m_pv    = 0;
  int m_ovf   = 0;
  int m_unf   = 0;

  function automatic int exp_push_ok();
    return (push_req && m_count < DEPTH) ? 1 : 0;
  endfunction

  function automatic int exp_pop_ok();
    return (pop_req && m_count > 0) ? 1 : 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_count = 0; m_wr = 0; m_rd = 0; m_pv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      int p, q;
      p = exp_push_ok();
      q = exp_pop_ok();
      if (FLAGS_ON != 0 && push_req && m_count == DEPTH) m_ovf = 1;
      if (FLAGS_ON != 0 && pop_req && m_count == 0)      m_unf = 1;
      m_count = m_count + p - q;
      m_wr    = (m_wr + p) % DEPTH;
      m_rd    = (m_rd + q) % DEPTH;
      m_pv    = q;
    end
  end

  // Per-cycle comparison, taken mid-cycle once the inputs have settled.
  always @(negedge clock) begin
    check("cyc_wr_en",     int'(wr_en),     exp_push_ok());
    check("cyc_rd_en",     int'(rd_en),     exp_pop_ok());
    check("cyc_wr_addr",   int'(wr_addr),   m_wr);
    check("cyc_rd_addr",   int'(rd_addr),   m_rd);
    check("cyc_count",     int'(count),     m_count);
    check("cyc_empty",     int'(empty),     (m_count == 0) ? 1 : 0);
    check("cyc_full",      int'(full),      (m_count == DEPTH) ? 1 : 0);
    check("cyc_pop_valid", int'(pop_valid), m_pv);
    check("cyc_overflow",  int'(overflow),  m_ovf);
    check("cyc_underflow", int'(underflow), m_unf);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic p, input logic q);
    push_req = p;
    pop_req  = q;
  endtask

  task automatic wait_mid();
    @(negedge clock);
    #1;
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int start_wr;
    int start_rd;

    reset = 1'b1;
    set_req(1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset, then idle.
    next_edge();
    wait_mid();
    check("rst_count",     int'(count),     0);
    check("rst_empty",     int'(empty),     1);
    check("rst_full",      int'(full),      0);
    check("rst_wr_addr",   int'(wr_addr),   0);
    check("rst_rd_addr",   int'(rd_addr),   0);
    check("rst_pop_valid", int'(pop_valid), 0);
    next_edge();

    // Sixteen pushes fill the FIFO.
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 1'b0);
      wait_mid();
      check("fill_wr_en",   int'(wr_en),   1);
      check("fill_wr_addr", int'(wr_addr), i);
      check("fill_full",    int'(full),    0);
      next_edge();
    end
    set_req(1'b0, 1'b0);
    wait_mid();
    check("fill_done_full",  int'(full),    1);
    check("fill_done_count", int'(count),   16);
    check("fill_done_wrap",  int'(wr_addr), 0);
    next_edge();

    // A 17th push is refused.
    set_req(1'b1, 1'b0);
    wait_mid();
    check("push_when_full_wr_en", int'(wr_en), 0);
    next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("overflow_flag", int'(overflow), FLAGS_ON);
    check("still_16",      int'(count),    16);
    next_edge();

    // Sixteen pops drain the FIFO. pop_valid is high from the second pop
    // cycle through the cycle after the last pop.
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b0, 1'b1);
      wait_mid();
      check("drain_rd_en",     int'(rd_en),     1);
      check("drain_rd_addr",   int'(rd_addr),   i);
      check("drain_pop_valid", int'(pop_valid), (i > 0) ? 1 : 0);
      next_edge();
    end
    set_req(1'b0, 1'b0);
    wait_mid();
    check("drain_pv_cycle17", int'(pop_valid), 1);
    check("drain_empty",      int'(empty),     1);
    check("drain_rd_wrap",    int'(rd_addr),   0);
    next_edge();

    // A further pop is refused.
    set_req(1'b0, 1'b1);
    wait_mid();
    check("pop_when_empty_rd_en", int'(rd_en), 0);
    next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("underflow_flag",   int'(underflow), FLAGS_ON);
    check("no_pv_after_refuse", int'(pop_valid), 0);
    next_edge();

    // EMPTY with push and pop together: only the push is taken.
    set_req(1'b1, 1'b1);
    wait_mid();
    check("empty_both_wr_en", int'(wr_en), 1);
    check("empty_both_rd_en", int'(rd_en), 0);
    next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("empty_both_count", int'(count), 1);
    next_edge();

    // Refill to full with 15 more pushes.
    set_req(1'b1, 1'b0);
    repeat (15) next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("refill_full", int'(full), 1);
    next_edge();

    // FULL with push and pop together: only the pop is taken.
    set_req(1'b1, 1'b1);
    wait_mid();
    check("full_both_wr_en", int'(wr_en), 0);
    check("full_both_rd_en", int'(rd_en), 1);
    next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("full_both_count", int'(count), 15);
    next_edge();

    // Ten pops bring the count to 5. Then push and pop are held for 20 cycles.
    set_req(1'b0, 1'b1);
    repeat (10) next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("five_count", int'(count), 5);
    start_wr = m_wr;
    start_rd = m_rd;
    next_edge();
    set_req(1'b1, 1'b1);
    repeat (20) next_edge();
    set_req(1'b0, 1'b0);
    wait_mid();
    check("steady_count",   int'(count),   5);
    check("steady_empty",   int'(empty),   0);
    check("steady_full",    int'(full),    0);
    check("steady_wr_addr", int'(wr_addr), (start_wr + 4) % DEPTH);
    check("steady_rd_addr", int'(rd_addr), (start_rd + 4) % DEPTH);
    next_edge();

    // Reset asserted in the cycle after rd_en clears everything at once.
    set_req(1'b0, 1'b1);
    next_edge();
    set_req(1'b0, 1'b0);
    check("pre_reset_pv", int'(pop_valid), 1);
    reset = 1'b1;
    #1;
    check("async_pop_valid", int'(pop_valid), 0);
    check("async_count",     int'(count),     0);
    check("async_empty",     int'(empty),     1);
    check("async_full",      int'(full),      0);
    check("async_wr_addr",   int'(wr_addr),   0);
    check("async_rd_addr",   int'(rd_addr),   0);
    check("async_overflow",  int'(overflow),  0);
    check("async_underflow", int'(underflow), 0);
    next_edge();
    reset = 1'b0;
    next_edge();
    wait_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Keeps the run bounded even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish by 200000");
    $fatal(1);
  end

endmodule
